// File: rtl/burst_pkg.sv
// Shared definitions for the burst detection / measurement chain.
//   state_e   : run-tracking FSM encoding (IDLE=0, RUN=1)
//   W_DEFAULT : default width of run-length counters
//   DROP_W    : width of the dropped-report counter
package burst_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int W_DEFAULT = 8;
    localparam int DROP_W    = 8;

endpackage

// File: rtl/burst_len_meter_if.sv
// Valid/ready report port carrying one measured run length.
//   len_valid : report held and not yet consumed
//   len_ready : consumer accepts the report at a posedge when len_valid is high
//   len       : run length in samples
//   len_sat   : run length saturated at 2^W-1
interface burst_len_meter_if #(
    parameter int W = 8
) ();

    logic         len_valid;
    logic         len_ready;
    logic [W-1:0] len;
    logic         len_sat;

    modport master (
        output len_valid,
        output len,
        output len_sat,
        input  len_ready
    );

    modport slave (
        input  len_valid,
        input  len,
        input  len_sat,
        output len_ready
    );

endinterface

// File: rtl/burst_len_meter_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : zero the count and the saturated flag (wins over inc)
//   inc       : add one, holding at 2^W-1
//   cnt       : current count
//   sat       : count has reached 2^W-1 since the last clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         sat_q, sat_d;

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (inc) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + W'(1);
            end
            sat_d = (cnt_d == '1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule

// File: rtl/burst_len_meter.sv
// Measures each run of consecutive 1s on x and reports runs of at least
// MIN_LEN samples through a one-entry valid/ready output register.
//   clk, rstn : clock, asynchronous active-low reset
//   x         : serial bit stream, sampled every posedge
//   active    : current run has reached MIN_LEN samples
//   drop_cnt  : reports lost because the output register was occupied (saturating)
//   rpt_if    : report port (len_valid/len_ready/len/len_sat)
module burst_len_meter
    import burst_pkg::*;
#(
    parameter int MIN_LEN = 3,
    parameter int W       = W_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              x,
    output logic              active,
    output logic [DROP_W-1:0] drop_cnt,
    burst_len_meter_if.master rpt_if
);

    localparam logic [W:0]   MIN_LEN_X = (W+1)'(MIN_LEN);
    localparam logic [W-1:0] MIN_M1    = W'(MIN_LEN - 1);

    state_e            state_q, state_d;
    logic              active_q, active_d;
    logic              len_valid_q, len_valid_d;
    logic [W-1:0]      len_q, len_d;
    logic              len_sat_q, len_sat_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [W-1:0]      cnt;
    logic              sat;
    logic              rpt;

    // Counter is zero throughout IDLE, so incrementing on the first 1 gives 1.
    sat_counter #(.W(W)) u_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (!x),
        .inc  (x),
        .cnt  (cnt),
        .sat  (sat)
    );

    assign rpt = (state_q == RUN) && !x && ({1'b0, cnt} >= MIN_LEN_X);

    always_comb begin
        state_d     = x ? RUN : IDLE;
        // cnt reaches MIN_LEN on this edge exactly when it currently holds MIN_LEN-1.
        active_d    = x && (active_q || (cnt == MIN_M1));
        len_valid_d = len_valid_q;
        len_d       = len_q;
        len_sat_d   = len_sat_q;
        drop_cnt_d  = drop_cnt_q;

        if (rpt && (!len_valid_q || rpt_if.len_ready)) begin
            len_valid_d = 1'b1;
            len_d       = cnt;
            len_sat_d   = sat;
        end else if (rpt) begin
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end else if (rpt_if.len_ready) begin
            len_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            active_q    <= 1'b0;
            len_valid_q <= 1'b0;
            len_q       <= '0;
            len_sat_q   <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            len_valid_q <= len_valid_d;
            len_q       <= len_d;
            len_sat_q   <= len_sat_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign active           = active_q;
    assign drop_cnt         = drop_cnt_q;
    assign rpt_if.len_valid = len_valid_q;
    assign rpt_if.len       = len_q;
    assign rpt_if.len_sat   = len_sat_q;

endmodule

// File: tb/tb_burst_len_meter.sv
// Directed bench for burst_len_meter: a table of per-cycle vectors on the
// default instance (MIN_LEN=3, W=8) plus hand-written saturation (W=4)
// and asynchronous-reset sequences.
module tb_burst_len_meter;

    logic       clk;
    logic       rstn;
    logic       x1, x2;
    logic       active1, active2;
    logic [7:0] drop1, drop2;

    burst_len_meter_if #(.W(8)) if1 ();
    burst_len_meter_if #(.W(4)) if2 ();

    burst_len_meter #(.MIN_LEN(3), .W(8)) dut1 (
        .clk      (clk),
        .rstn     (rstn),
        .x        (x1),
        .active   (active1),
        .drop_cnt (drop1),
        .rpt_if   (if1.master)
    );

    burst_len_meter #(.MIN_LEN(3), .W(4)) dut2 (
        .clk      (clk),
        .rstn     (rstn),
        .x        (x2),
        .active   (active2),
        .drop_cnt (drop2),
        .rpt_if   (if2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       x;
        logic       rdy;
        logic       a;
        logic       v;
        logic [7:0] l;
        logic       s;
        logic [7:0] d;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic xv, input logic r, input logic a, input logic v,
                       input logic [7:0] l, input logic s, input logic [7:0] d);
        vec_t t;
        t.x = xv; t.rdy = r; t.a = a; t.v = v; t.l = l; t.s = s; t.d = d;
        tbl.push_back(t);
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after the posedge.
    task automatic tick1(input logic xv, input logic r);
        x1 = xv;
        if1.len_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic tick2(input logic xv);
        x2 = xv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        x1 = 1'b0;
        x2 = 1'b0;
        if1.len_ready = 1'b0;
        if2.len_ready = 1'b1;

        //  x  rdy act val len sat drop
        // basic report: run of 4
        add(0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 1, 4, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        // short run of 2: silently discarded
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        // back-pressure: runs 3,5,4 with ready low
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 3, 0, 0);
        add(1, 0, 0, 1, 3, 0, 0);
        add(1, 0, 0, 1, 3, 0, 0);
        add(1, 0, 1, 1, 3, 0, 0);
        add(1, 0, 1, 1, 3, 0, 0);
        add(1, 0, 1, 1, 3, 0, 0);
        add(0, 0, 0, 1, 3, 0, 1);
        add(1, 0, 0, 1, 3, 0, 1);
        add(1, 0, 0, 1, 3, 0, 1);
        add(1, 0, 1, 1, 3, 0, 1);
        add(1, 0, 1, 1, 3, 0, 1);
        add(0, 0, 0, 1, 3, 0, 2);
        add(0, 1, 0, 0, 0, 0, 2);
        // simultaneous pop/push: hold 3, then a run of 6 ends with ready high
        add(1, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0, 2);
        add(1, 0, 1, 0, 0, 0, 2);
        add(0, 0, 0, 1, 3, 0, 2);
        add(1, 0, 0, 1, 3, 0, 2);
        add(1, 0, 0, 1, 3, 0, 2);
        add(1, 0, 1, 1, 3, 0, 2);
        add(1, 0, 1, 1, 3, 0, 2);
        add(1, 0, 1, 1, 3, 0, 2);
        add(1, 0, 1, 1, 3, 0, 2);
        add(0, 1, 0, 1, 6, 0, 2);
        add(0, 1, 0, 0, 0, 0, 2);

        repeat (2) @(posedge clk);
        #1;
        chk("reset active", {31'b0, active1}, 32'd0);
        chk("reset len_valid", {31'b0, if1.len_valid}, 32'd0);
        chk("reset len", {24'b0, if1.len}, 32'd0);
        chk("reset len_sat", {31'b0, if1.len_sat}, 32'd0);
        chk("reset drop_cnt", {24'b0, drop1}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            tick1(tbl[i].x, tbl[i].rdy);
            chk($sformatf("v%0d active", i), {31'b0, active1}, {31'b0, tbl[i].a});
            chk($sformatf("v%0d len_valid", i), {31'b0, if1.len_valid}, {31'b0, tbl[i].v});
            chk($sformatf("v%0d drop_cnt", i), {24'b0, drop1}, {24'b0, tbl[i].d});
            if (tbl[i].v) begin
                chk($sformatf("v%0d len", i), {24'b0, if1.len}, {24'b0, tbl[i].l});
                chk($sformatf("v%0d len_sat", i), {31'b0, if1.len_sat}, {31'b0, tbl[i].s});
            end
        end

        // Saturation on the W=4 instance: 20 ones then a zero.
        for (int i = 1; i <= 20; i++) begin
            tick2(1'b1);
            if (i == 2 || i == 3 || i == 20) begin
                chk($sformatf("sat active after %0d ones", i), {31'b0, active2}, (i >= 3) ? 32'd1 : 32'd0);
            end
            if (i == 14) begin
                chk("sat len_valid mid-run", {31'b0, if2.len_valid}, 32'd0);
            end
        end
        tick2(1'b0);
        chk("sat len_valid", {31'b0, if2.len_valid}, 32'd1);
        chk("sat len", {28'b0, if2.len}, 32'd15);
        chk("sat len_sat", {31'b0, if2.len_sat}, 32'd1);
        chk("sat active", {31'b0, active2}, 32'd0);
        tick2(1'b0);
        chk("sat len_valid pop", {31'b0, if2.len_valid}, 32'd0);

        // Short run of 14 on W=4 must not report saturation.
        for (int i = 0; i < 14; i++) tick2(1'b1);
        tick2(1'b0);
        chk("w4 len 14", {28'b0, if2.len}, 32'd14);
        chk("w4 len_sat 14", {31'b0, if2.len_sat}, 32'd0);

        // Asynchronous reset in the middle of a run of 5.
        for (int i = 0; i < 5; i++) tick1(1'b1, 1'b0);
        chk("pre-reset active", {31'b0, active1}, 32'd1);
        #3;
        rstn = 1'b0;
        #1;
        chk("async rst active", {31'b0, active1}, 32'd0);
        chk("async rst len_valid", {31'b0, if1.len_valid}, 32'd0);
        chk("async rst len", {24'b0, if1.len}, 32'd0);
        chk("async rst len_sat", {31'b0, if1.len_sat}, 32'd0);
        chk("async rst drop_cnt", {24'b0, drop1}, 32'd0);
        @(negedge clk);
        x1 = 1'b1;
        if1.len_ready = 1'b1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) tick1(1'b1, 1'b1);
        chk("post-reset active", {31'b0, active1}, 32'd1);
        tick1(1'b0, 1'b1);
        chk("post-reset len_valid", {31'b0, if1.len_valid}, 32'd1);
        chk("post-reset len", {24'b0, if1.len}, 32'd3);
        chk("post-reset drop_cnt", {24'b0, drop1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_len_meter.md
# burst_len_meter

Downstream consumer of the serial burst-detection stage. Samples the same single-bit stream `x`, measures the length of every run of consecutive 1s, and reports each run that reaches `MIN_LEN` samples as a length word on a valid/ready output port. A one-entry output register decouples the stream from the consumer. A saturating drop counter records reports lost to back-pressure.

## Interface
- `MIN_LEN`, 3: minimum run length, in samples, that is reported. Legal range is 1 .. 2^W-1.
- `W`, 8: width of the length counter and of the `len` output.
- `clk` input 1: sole clock; all state updates on posedge.
- `rstn` input 1: asynchronous, active-low reset.
- `x` input 1: serial bit stream, sampled every posedge.
- `active` output 1: registered; high while the current run has reached `MIN_LEN`.
- `len_valid` output 1: output register holds an unconsumed report.
- `len_ready` input 1: consumer accepts the report when `len_valid && len_ready` at a posedge.
- `len` output W: reported run length, in samples.
- `len_sat` output 1: the reported run reached 2^W-1 and the count saturated.
- `drop_cnt` output 8: count of reports discarded because the output register was occupied; saturates at 255.

## Operation
- **FSM states:**
  - IDLE: `x` sampled 0.
  - RUN: counting consecutive 1s.
- **Transitions:**
  - IDLE, `x`=1: go to RUN, `cnt`<=1.
  - RUN, `x`=1: `cnt`<=`cnt`+1, saturating at 2^W-1 (no wrap); `sat`<=1 once the saturated value is reached.
  - RUN, `x`=0: the burst ends. Go to IDLE and clear `cnt` and `sat`.
- **At burst end:**
  - If `cnt` >= `MIN_LEN`, generate a report {`cnt`, `sat`}.
  - Runs shorter than `MIN_LEN` are discarded silently and never counted as drops.
- **`active`:**
  - Set at the edge where `cnt` becomes >= `MIN_LEN` while in RUN.
  - Cleared at the edge that samples `x`=0.
  - This matches the detector stage's `y`, delayed one cycle.
- **Output register, at each posedge:**
  - Report generated and (`!len_valid` or `len_ready`): load `len`/`len_sat` and set `len_valid`. A simultaneous pop and push yields the new report with `len_valid` staying high.
  - Report generated, `len_valid` high and `len_ready` low: keep the held report and increment `drop_cnt` (saturating).
  - No report and `len_ready` high: clear `len_valid`.
- **Holding rules:**
  - `len` and `len_sat` hold their values while `len_valid` is high and `len_ready` is low.
  - `len` is don't-care when `len_valid` is low, but is never driven X.
- **Reset:**
  - Clears the FSM to IDLE and zeroes `cnt`, `sat`, `active`, `len_valid`, `len`, `len_sat` and `drop_cnt`.
  - A burst in progress when reset asserts is lost.
  - After reset releases with `x` already high, the run counts from the first sampled edge.

## Timing
- All outputs are registered. Reset values are all 0.
- **Report latency:** the burst-end sample (`x`=0 at edge k) gives `len_valid` high after edge k, i.e. one cycle after the last 1.
- **`active` timing:** `active` rises after the edge that samples the `MIN_LEN`-th consecutive 1, and falls after the edge that samples the first 0.
- **Back-to-back runs:** 1,0,1,0 patterns are legal. IDLE lasts one sample minimum, so reports arrive at most every other cycle; the consumer needs no more than 50% throughput.
- **`MIN_LEN`=1:** every run is reported. `active` rises one cycle after the first 1.
- **Saturation:** a run of 2^W or more samples reports `len`=2^W-1 with `len_sat`=1.

## Structure
- Shared package/header `burst_pkg` holds:
  - FSM state encoding (IDLE=0, RUN=1);
  - default `W`;
  - `DROP_W`=8.
  The detector stage and the report consumers use the same package.
- One sub-module, `sat_counter #(W)`:
  - inputs: clear, increment enable;
  - outputs: count, saturated flag.
- The FSM, output register and drop counter are in the top level. Target size is 150–250 lines of RTL.

## Test plan
- **Basic report:** `MIN_LEN`=3, `len_ready`=1; `x`=0,1,1,1,1,0 → single `len_valid` pulse with `len`=4 one cycle after the last 1; `active` high for 2 cycles.
- **Short run:** `x`=1,1,0 with `MIN_LEN`=3 → no `len_valid`, `drop_cnt`=0, `active` never high.
- **Back-pressure:**
  - Stimulus: `len_ready`=0; runs of length 3, 5, 4 separated by single 0s.
  - Response: `len` stays 3, `drop_cnt`=2.
  - Then `len_ready`=1 for one cycle → `len_valid` falls.
- **Simultaneous pop/push:** `len_ready`=1 exactly on the edge a new run of 6 ends while a report of 3 is held → `len` becomes 6, `len_valid` stays 1, `drop_cnt` unchanged.
- **Saturation:** `W`=4; 20 consecutive 1s then 0 → `len`=15, `len_sat`=1.
- **Reset mid-burst:** assert `rstn`=0 asynchronously mid-clock during a run of 5 → all outputs 0 immediately. Release with `x`=1 for 3 more cycles, then 0 → `len`=3.
